// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the neuron weight loader.
package neuron_pkg;

  localparam int N_WEIGHTS_DEFAULT = 400;
  localparam int SEL_W             = 9;
  localparam int WORD_W_DEFAULT    = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BIAS    = 3'd1,
    WEIGHTS = 3'd2,
    FINAL   = 3'd3,
    DONE    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/neuron_weight_loader.sv
// Streams one neuron's parameters (bias first, then weights 1..N) into the
// neuron's register file. Weights are written as they arrive; the bias is
// held back and written last so the neuron sees a complete set when the
// bias write lands.
module neuron_weight_loader
  import neuron_pkg::*;
#(
  parameter int N_WEIGHTS = N_WEIGHTS_DEFAULT,
  parameter int WORD_W    = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_weight,
  output logic [SEL_W-1:0]  weight_sel,
  output logic [WORD_W-1:0] weight_bus,
  output logic              busy,
  output logic              load_done
);

  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_WEIGHTS);
  localparam logic [SEL_W-1:0] FIRST_IDX = 9'd1;
  localparam logic [SEL_W-1:0] BIAS_SEL  = 9'd0;

  loader_state_t     state, state_nxt;
  logic [SEL_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] bias_reg, bias_nxt;
  logic              write_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [WORD_W-1:0] bus_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              xfer;

  // Source handshake depends only on state so upstream sees no path from abort.
  assign in_ready = (state == BIAS) || (state == WEIGHTS);
  assign xfer     = in_valid && in_ready;

  // Next-state and next-output decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bias_nxt  = bias_reg;
    write_nxt = 1'b0;
    sel_nxt   = weight_sel;
    bus_nxt   = weight_bus;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = FIRST_IDX;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state_nxt = BIAS;
            idx_nxt   = FIRST_IDX;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        BIAS: begin
          if (xfer) begin
            bias_nxt  = in_data;
            state_nxt = WEIGHTS;
          end else begin
            state_nxt = BIAS;
          end
        end
        WEIGHTS: begin
          if (xfer) begin
            write_nxt = 1'b1;
            sel_nxt   = idx;
            bus_nxt   = in_data;
            if (idx == LAST_IDX) begin
              // Index parks on the last weight; it never wraps inside a load.
              state_nxt = FINAL;
            end else begin
              idx_nxt = idx + 9'd1;
            end
          end else begin
            state_nxt = WEIGHTS;
          end
        end
        FINAL: begin
          write_nxt = 1'b1;
          sel_nxt   = BIAS_SEL;
          bus_nxt   = bias_reg;
          state_nxt = DONE;
        end
        DONE: begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= FIRST_IDX;
      bias_reg     <= {WORD_W{1'b0}};
      write_weight <= 1'b0;
      weight_sel   <= BIAS_SEL;
      weight_bus   <= {WORD_W{1'b0}};
      busy         <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      bias_reg     <= bias_nxt;
      write_weight <= write_nxt;
      weight_sel   <= sel_nxt;
      weight_bus   <= bus_nxt;
      busy         <= busy_nxt;
      load_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Directed bench for neuron_weight_loader: full loads, stalls, abort, reset
// mid-load, ignored load_start, and a single-weight configuration.
module tb_neuron_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, abort, in_valid;
  logic [63:0] in_data;
  logic        in_ready, write_weight, busy, load_done;
  logic [8:0]  weight_sel;
  logic [63:0] weight_bus;

  logic        ls1, ab1, iv1;
  logic [63:0] id1;
  logic        rdy1, wr1, busy1, done1;
  logic [8:0]  sel1;
  logic [63:0] bus1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int bias_edge;
  int qs;

  int          wq_sel[$];
  logic [63:0] wq_bus[$];
  int          wq_cyc[$];
  int          dq[$];

  neuron_weight_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_weight(write_weight), .weight_sel(weight_sel),
    .weight_bus(weight_bus), .busy(busy), .load_done(load_done)
  );

  neuron_weight_loader #(.N_WEIGHTS(1), .WORD_W(64)) dut1 (
    .clk(clk), .rst(rst), .load_start(ls1), .abort(ab1),
    .in_valid(iv1), .in_data(id1), .in_ready(rdy1),
    .write_weight(wr1), .weight_sel(sel1),
    .weight_bus(bus1), .busy(busy1), .load_done(done1)
  );

  always #5 clk = ~clk;

  // Cycle counter, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor for the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_weight === 1'b1) begin
      wq_sel.push_back(int'(weight_sel));
      wq_bus.push_back(weight_bus);
      wq_cyc.push_back(cyc);
    end
    if (load_done === 1'b1) dq.push_back(cyc);
  end

  function automatic logic [63:0] wval(input int k);
    return $realtobits(real'(k) / 512000.0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_queues();
    wq_sel.delete(); wq_bus.delete(); wq_cyc.delete(); dq.delete();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && dq.size() == 0; i++) tick();
    check({tag, " done seen"}, 64'(dq.size() > 0), 64'd1);
  endtask

  // Checks the 401-write sequence: sel 1..400 with their words, then bias.
  task automatic verify_seq(input string tag, input logic [63:0] exp_bias, input int spacing);
    int bad;
    check({tag, " write count"}, 64'(wq_sel.size()), 64'd401);
    if (wq_sel.size() == 401) begin
      bad = 0;
      for (int i = 0; i < 400; i++) begin
        if (wq_sel[i] != i + 1 || wq_bus[i] !== wval(i + 1)) bad++;
        if (i > 0 && wq_cyc[i] - wq_cyc[i-1] != spacing) bad++;
      end
      check({tag, " weight order"}, 64'(bad), 64'd0);
      check({tag, " bias sel"}, 64'(wq_sel[400]), 64'd0);
      check({tag, " bias value"}, wq_bus[400], exp_bias);
      check({tag, " bias follows"}, 64'(wq_cyc[400] - wq_cyc[399]), 64'd1);
    end
    check({tag, " done count"}, 64'(dq.size()), 64'd1);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 64'd0;
    ls1 = 1'b0; ab1 = 1'b0; iv1 = 1'b0; id1 = 64'd0;
    tick(); tick();
    check("reset write", 64'(write_weight), 64'd0);
    check("reset sel", 64'(weight_sel), 64'd0);
    check("reset bus", weight_bus, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(load_done), 64'd0);
    check("reset ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("idle ignores valid", 64'(in_ready), 64'd0);
    check("idle no write", 64'(write_weight), 64'd0);

    // Full load, valid held high.
    clear_queues();
    start_load();
    check("bias ready", 64'(in_ready), 64'd1);
    check("bias busy", 64'(busy), 64'd1);
    in_data = $realtobits(0.5);
    tick();
    bias_edge = cyc;
    check("bias no write", 64'(write_weight), 64'd0);
    for (int k = 1; k <= 400; k++) begin
      in_data = wval(k);
      tick();
    end
    in_valid = 1'b0;
    check("final ready low", 64'(in_ready), 64'd0);
    wait_done("full");
    verify_seq("full", $realtobits(0.5), 1);
    if (dq.size() > 0) check("full done cycle", 64'(dq[0] - bias_edge), 64'd402);
    check("full busy after", 64'(busy), 64'd0);
    tick();
    check("idle hold sel", 64'(weight_sel), 64'd0);
    check("idle hold bus", weight_bus, $realtobits(0.5));
    check("idle write low", 64'(write_weight), 64'd0);
    check("done one cycle", 64'(load_done), 64'd0);

    // Valid toggling during the weight phase.
    clear_queues();
    start_load();
    in_valid = 1'b1; in_data = $realtobits(0.75);
    tick();
    for (int k = 1; k <= 400; k++) begin
      in_valid = 1'b1; in_data = wval(k);
      tick();
      in_valid = 1'b0; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
    end
    wait_done("stall");
    verify_seq("stall", $realtobits(0.75), 2);

    // Abort after weight 200, then a fresh full load.
    clear_queues();
    start_load();
    in_valid = 1'b1; in_data = $realtobits(0.5);
    tick();
    for (int k = 1; k <= 200; k++) begin
      in_data = wval(k);
      tick();
    end
    abort = 1'b1; in_data = wval(201);
    tick();
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort write", 64'(write_weight), 64'd0);
    check("abort ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("abort write count", 64'(wq_sel.size()), 64'd200);
    if (wq_sel.size() > 0) check("abort last sel", 64'(wq_sel[wq_sel.size()-1]), 64'd200);
    check("abort no done", 64'(dq.size()), 64'd0);
    abort = 1'b1; load_start = 1'b1;
    tick();
    abort = 1'b0; load_start = 1'b0;
    check("abort+start ready", 64'(in_ready), 64'd0);
    check("abort+start busy", 64'(busy), 64'd0);
    clear_queues();
    start_load();
    in_data = $realtobits(0.5);
    tick();
    for (int k = 1; k <= 400; k++) begin
      in_data = wval(k);
      tick();
    end
    in_valid = 1'b0;
    wait_done("reload");
    verify_seq("reload", $realtobits(0.5), 1);

    // load_start pulsed mid-load is ignored.
    clear_queues();
    start_load();
    in_valid = 1'b1; in_data = $realtobits(0.25);
    tick();
    for (int k = 1; k <= 400; k++) begin
      in_data = wval(k);
      load_start = (k == 100) ? 1'b1 : 1'b0;
      tick();
    end
    load_start = 1'b0; in_valid = 1'b0;
    wait_done("restart");
    for (int i = 0; i < 5; i++) tick();
    verify_seq("restart", $realtobits(0.25), 1);

    // Single-weight instance.
    ls1 = 1'b1;
    tick();
    ls1 = 1'b0;
    check("n1 ready", 64'(rdy1), 64'd1);
    iv1 = 1'b1; id1 = $realtobits(1.0);
    tick();
    id1 = $realtobits(0.25);
    tick();
    iv1 = 1'b0;
    check("n1 w write", 64'(wr1), 64'd1);
    check("n1 w sel", 64'(sel1), 64'd1);
    check("n1 w bus", bus1, $realtobits(0.25));
    tick();
    check("n1 b write", 64'(wr1), 64'd1);
    check("n1 b sel", 64'(sel1), 64'd0);
    check("n1 b bus", bus1, $realtobits(1.0));
    check("n1 b no done", 64'(done1), 64'd0);
    tick();
    check("n1 done", 64'(done1), 64'd1);
    check("n1 done write low", 64'(wr1), 64'd0);
    check("n1 done busy", 64'(busy1), 64'd0);
    tick();
    check("n1 done pulse", 64'(done1), 64'd0);

    // Reset asserted after weight 50.
    clear_queues();
    start_load();
    in_valid = 1'b1; in_data = $realtobits(0.5);
    tick();
    for (int k = 1; k <= 50; k++) begin
      in_data = wval(k);
      tick();
    end
    rst = 1'b1;
    #1;
    check("rst write", 64'(write_weight), 64'd0);
    check("rst sel", 64'(weight_sel), 64'd0);
    check("rst bus", weight_bus, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(load_done), 64'd0);
    check("rst ready", 64'(in_ready), 64'd0);
    qs = wq_sel.size();
    check("rst writes before", 64'(qs), 64'd49);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst no later writes", 64'(wq_sel.size()), 64'(qs));
    check("rst no done", 64'(dq.size()), 64'd0);
    check("rst stays idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_weight_loader.md
NEURON_WEIGHT_LOADER -- requirements
Module: neuron_weight_loader

Interface
REQ-001 SHALL have parameter N_WEIGHTS, default 400, number of weight words per neuron (1..511).
REQ-002 SHALL have parameter WORD_W, default 64, width of one IEEE-754 double word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to begin loading one neuron.
REQ-006 SHALL have port abort  input  1  cancels an in-progress load.
REQ-007 SHALL have port in_valid  input  1  source word available.
REQ-008 SHALL have port in_data  input  WORD_W  source word: bias first, then weights 1..N_WEIGHTS.
REQ-009 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-010 SHALL have port write_weight  output  1  neuron weight-register write strobe.
REQ-011 SHALL have port weight_sel  output  9  target register: 0 = bias, 1..N_WEIGHTS = weights.
REQ-012 SHALL have port weight_bus  output  WORD_W  value written to the selected register.
REQ-013 SHALL have port busy  output  1  high from accepted load_start until the done pulse or abort.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse when the bias write has been issued.

Function
REQ-015 SHALL implement states IDLE, BIAS, WEIGHTS, FINAL, DONE.
REQ-016 In IDLE, load_start SHALL move to BIAS next cycle; in_valid SHALL be ignored.
REQ-017 in_ready SHALL be high only in BIAS and WEIGHTS, derived combinationally from state.
REQ-018 Transfer SHALL occur only on in_valid && in_ready; in_valid low SHALL stall with no write.
REQ-019 In BIAS, the transferred word SHALL be stored in an internal bias register and the state SHALL become WEIGHTS; no write issued.
REQ-020 In WEIGHTS, transfer k (k = 1..N_WEIGHTS) SHALL produce, on the next cycle, write_weight=1, weight_sel=k, weight_bus=in_data.
REQ-021 After transfer N_WEIGHTS, the state SHALL become FINAL; in_ready SHALL drop in the same cycle it moves.
REQ-022 In FINAL, the loader SHALL register write_weight=1, weight_sel=0, weight_bus=bias for exactly one cycle, then enter DONE.
REQ-023 DONE SHALL assert load_done for one cycle and return to IDLE; busy SHALL drop with it.
REQ-024 write_weight SHALL be low on every cycle without a write; weight_sel/weight_bus SHALL hold their last values when idle.
REQ-025 At most one write per cycle; back-to-back transfers SHALL give back-to-back writes (N_WEIGHTS+1 writes total per load).
REQ-026 load_start while busy SHALL be ignored.
REQ-027 abort SHALL take priority over all other inputs: next cycle state IDLE, write_weight 0, busy 0, no load_done.
REQ-028 abort and load_start in the same IDLE cycle: abort wins; remains IDLE.
REQ-029 Weight index counter SHALL be 9 bits, reset to 1 on each accepted load_start, and never wrap within a load.

Reset
REQ-030 rst SHALL force state IDLE, write_weight 0, weight_sel 0, weight_bus 0, busy 0, load_done 0, bias register 0, index 1.
REQ-031 Reset asserted mid-load SHALL discard the load; no further writes after reset deassertion until a new load_start.

Structure
REQ-032 Shared package neuron_pkg SHALL hold N_WEIGHTS default (400), SEL_W (9), WORD_W (64), and the loader state enum.
REQ-033 No sub-module is required; single module with registered outputs.

Verification
REQ-034 Full load, in_valid always high, bias 0.5, weights w[k]=k/512000 -> writes sel 1..400 in order on consecutive cycles, then sel 0 = 0.5, load_done 402 cycles after first transfer (402nd cycle after BIAS accept +1).
REQ-035 in_valid toggling 1,0,1,0 during WEIGHTS -> exactly one write per accepted word, none on stalled cycles, sel still 1..400 contiguous.
REQ-036 abort at weight 200 -> no write after sel 200, busy 0 next cycle, no load_done; a fresh load then completes normally.
REQ-037 load_start pulsed during WEIGHTS -> ignored; exactly 401 writes, single load_done.
REQ-038 rst asserted at weight 50 for one cycle -> all outputs 0 immediately, in_ready 0, no writes until next load_start.
REQ-039 N_WEIGHTS=1, bias 1.0, weight 0.25 -> writes (sel1, 0.25) then (sel0, 1.0), load_done following cycle.
